// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave : SPI mode 0 (CPOL=0, CPHA=0) target, MSB first.
//
// sclk, mosi and cs_n are oversampled on clk through SYNC_STAGES-deep
// synchronisers. Edges come from comparing the synchronised sample with
// the one before it. Received words are presented on rx_data with a
// one-clk rx_valid pulse. A single-entry tx holding buffer, written through
// a tx_load/tx_ready handshake, supplies the byte shifted out on miso.
//
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   sclk, cs_n, mosi SPI pins from the master (asynchronous to clk)
//   miso             serial data to the master (0 outside a frame)
//   tx_data/tx_load  byte for the next word; accepted only while tx_ready=1
//   tx_ready         tx holding buffer empty
//   rx_data          last completed word; held until the next one completes
//   rx_valid         one-clk pulse when rx_data updates
//   busy             frame active (synchronised cs_n low)
//
// Optional build macro SPI_SLAVE_OVERRUN_EN adds:
//   rx_ack           acknowledges the current rx word, clears overrun
//   overrun          sticky: a word completed while the previous one was
//                    still unacknowledged
// ---------------------------------------------------------------------------
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic                  rx_ack,
  output logic                  overrun
`endif
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // ---------------------------------------------------------------------
  // Input synchronisers. cs_n resets to 0 on purpose: if reset lands
  // mid-frame with cs_n held low, no falling edge is seen afterwards, so
  // the frame only resumes once cs_n has gone high and low again.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s &  sclk_prev;
  assign cs_fall   = ~cs_s   &  cs_prev;
  assign cs_rise   =  cs_s   & ~cs_prev;

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

  // ---------------------------------------------------------------------
  // Word control
  // ---------------------------------------------------------------------
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift, tx_shift, tx_buf;
  logic                  word_full, word_done, word_start, abort;

  // word_full is seen one clk after the last rising edge; that clk both
  // publishes the word and reloads tx for a back-to-back word.
  assign word_full  = (bit_cnt == CW'(DATA_WIDTH));
  assign word_done  = busy && word_full;
  assign word_start = ((state == IDLE) && cs_fall) || (busy && word_full && !cs_rise);
  assign abort      = busy && cs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (abort || word_done) begin
      bit_cnt  <= '0;
      rx_shift <= abort ? '0 : rx_shift;
    end else if (busy && sclk_rise) begin
      bit_cnt  <= bit_cnt + CW'(1);
      rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= word_done;
      if (word_done) rx_data <= rx_shift;
    end
  end

  // ---------------------------------------------------------------------
  // Transmit path. A falling edge with bit_cnt==0 is the one that follows
  // the last bit of a word: the reload has already put the next word's
  // MSB on miso, so it must not be shifted away.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
      miso     <= 1'b0;
    end else if (abort) begin
      tx_shift <= '0;
      miso     <= 1'b0;
    end else if (word_start) begin
      tx_shift <= tx_ready ? '0   : tx_buf;
      miso     <= tx_ready ? 1'b0 : tx_buf[DATA_WIDTH-1];
    end else if (busy && sclk_fall && (bit_cnt != '0)) begin
      tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      miso     <= tx_shift[DATA_WIDTH-2];
    end
  end

  // Holding buffer. A word start that drains a full buffer cannot collide
  // with an accepted tx_load, since tx_load is only taken while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf   <= '0;
      tx_ready <= 1'b1;
    end else if (word_start && !tx_ready) begin
      tx_ready <= 1'b1;
    end else if (tx_load && tx_ready) begin
      tx_buf   <= tx_data;
      tx_ready <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  // rx_pending marks an unacknowledged word. An ack arriving in the same
  // clk as a completion acknowledges the older word, so no overrun.
  logic rx_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_pending <= 1'b0;
      overrun    <= 1'b0;
    end else if (word_done) begin
      rx_pending <= 1'b1;
      if (rx_pending && !rx_ack) overrun <= 1'b1;
      else if (rx_ack)           overrun <= 1'b0;
    end else if (rx_ack) begin
      rx_pending <= 1'b0;
      overrun    <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave : directed bench for spi_slave. A bench-side SPI master drives
// frames; a queue of expected words plus a held copy of the last word model
// rx_data/rx_valid, and a negedge compare process checks them every cycle.
// ---------------------------------------------------------------------------
module tb_spi_slave;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int H  = 6;   // sclk half period and cs setup, in clk periods

  logic          clk = 1'b0;
  logic          rst_n, sclk, cs_n, mosi, miso;
  logic [DW-1:0] tx_data, rx_data;
  logic          tx_load, tx_ready, rx_valid, busy;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic          rx_ack, overrun;
`endif

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .rx_ack(rx_ack), .overrun(overrun)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model + per-cycle compare ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_rx = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      model_rx = '0;
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data",  rx_data,  0);
      chk("rst_miso",     miso,     0);
      chk("rst_busy",     busy,     0);
      chk("rst_tx_ready", tx_ready, 1);
    end else begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rx_valid act=1 exp=0 data=%0h t=%0t", rx_data, $time);
        end else begin
          model_rx = exp_q.pop_front();
          chk("rx_word", rx_data, model_rx);
        end
      end else begin
        chk("rx_hold", rx_data, model_rx);
      end
      if (!busy) chk("idle_miso", miso, 0);
    end
  end

  // ---------------- master side ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] d);
    tx_data = d;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    tick(H);
  endtask

  task automatic cs_high();
    tick(H);
    cs_n = 1'b1;
    tick(2*H);
  endtask

  task automatic xfer(input logic [DW-1:0] tx, input int nbits, output logic [DW-1:0] rx);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[DW-1-i];
      tick(H);
      sclk = 1'b1;
      r = {r[DW-2:0], miso};
      tick(H);
      sclk = 1'b0;
    end
    rx = r;
  endtask

  task automatic frame(input logic [DW-1:0] tx, output logic [DW-1:0] rx);
    cs_low();
    xfer(tx, DW, rx);
    cs_high();
  endtask

  logic [DW-1:0] r, r2;
  logic [DW-1:0] m_tx[3] = '{8'h91, 8'hF0, 8'h12};
  logic [DW-1:0] s_tx[3] = '{8'h01, 8'h02, 8'h03};

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_load = 1'b0; tx_data = '0;
`ifdef SPI_SLAVE_OVERRUN_EN
    rx_ack = 1'b0;
`endif
    // 1. reset with random inputs
    for (int i = 0; i < 6; i++) begin
      tick(1);
      sclk = 1'($urandom); mosi = 1'($urandom); cs_n = 1'($urandom);
      tx_data = 8'($urandom); tx_load = 1'($urandom);
    end
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_rx_data",  rx_data,  8'h00);
    cs_n = 1'b1; sclk = 1'b0; tx_load = 1'b0; mosi = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);

    // 2. single word, second load while full is ignored
    load(8'h3C);
    chk("t2_ready_after_load", tx_ready, 0);
    load(8'h77);
    chk("t2_ready_ignored_load", tx_ready, 0);
    exp_q.push_back(8'hAA);
    cs_n = 1'b0;
    tick(SS + 2);
    chk("t2_ready_at_word_start", tx_ready, 1);
    tick(H - SS - 2);
    xfer(8'hAA, DW, r);
    cs_high();
    chk("t2_master_rx", r, 8'h3C);
    chk("t2_rx_data", rx_data, 8'hAA);

    // 3. three separate frames
    for (int i = 0; i < 3; i++) begin
      load(s_tx[i]);
      exp_q.push_back(m_tx[i]);
      frame(m_tx[i], r);
      chk("t3_master_rx", r, s_tx[i]);
      chk("t3_rx_data", rx_data, m_tx[i]);
    end

    // 4. underrun
    exp_q.push_back(8'h55);
    frame(8'h55, r);
    chk("t4_underrun_rx", r, 8'h00);
    chk("t4_rx_data", rx_data, 8'h55);

    // 5. abort after 5 bits; buffer loaded mid-frame survives the abort
    cs_low();
    load(8'h6E);
    xfer(8'hFF, 5, r);
    cs_high();
    chk("t5_abort_rx_data", rx_data, 8'h55);
    chk("t5_abort_miso", miso, 0);
    chk("t5_abort_ready", tx_ready, 0);
    exp_q.push_back(8'hC3);
    frame(8'hC3, r);
    chk("t5_rx_data", rx_data, 8'hC3);
    chk("t5_kept_buffer", r, 8'h6E);

    // 7. tx_load in the same clk as an empty-buffer word start
    cs_n = 1'b0;
    tick(SS);
    tx_data = 8'h81;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    chk("t7_ready_after_race", tx_ready, 0);
    tick(H - SS - 1);
    exp_q.push_back(8'h18);
    exp_q.push_back(8'h24);
    xfer(8'h18, DW, r);
    xfer(8'h24, DW, r2);
    cs_high();
    chk("t7_word0_zero", r, 8'h00);
    chk("t7_word1_held", r2, 8'h81);
    chk("t7_rx_data", rx_data, 8'h24);
    chk("t7_ready_end", tx_ready, 1);

    // 8. reset mid-frame, cs_n stays low: frame must not resume
    cs_low();
    xfer(8'hF0, 3, r);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    chk("t8_busy_after_rst", busy, 0);
    xfer(8'hA5, DW, r);
    chk("t8_no_resume_miso", r, 8'h00);
    chk("t8_busy_still_idle", busy, 0);
    cs_high();
    chk("t8_rx_data", rx_data, 8'h00);
    load(8'h42);
    exp_q.push_back(8'h99);
    frame(8'h99, r);
    chk("t8_recover_rx", r, 8'h42);
    chk("t8_recover_rx_data", rx_data, 8'h99);

`ifdef SPI_SLAVE_OVERRUN_EN
    // 6. overrun
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    chk("t6_overrun_cleared", overrun, 0);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    cs_low();
    xfer(8'hA5, DW, r);
    chk("t6_overrun_word1", overrun, 0);
    xfer(8'h5A, DW, r);
    chk("t6_overrun_word2", overrun, 1);
    cs_high();
    chk("t6_rx_data", rx_data, 8'h5A);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    chk("t6_ack_clears", overrun, 0);
`endif

    tick(4);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Single-slave SPI target, mode 0 (CPOL=0, CPHA=0), MSB first. It is the peripheral end of the link driven by spi_master.
- Oversamples the master's sclk/mosi/cs_n on the local system clock and deserialises mosi into parallel bytes.
- Serialises a host-supplied byte onto miso in the same frame.
- Presents a valid/ready style parallel interface to local logic.

Parameters:
- DATA_WIDTH, 8, bits per SPI word; also the width of rx_data and tx_data.
- SYNC_STAGES, 2, flops in each input synchroniser (sclk, mosi, cs_n); minimum 2.

Ports:
- clk       input   1           system clock; all logic on rising edge
- rst_n     input   1           asynchronous active-low reset
- sclk      input   1           SPI clock from master, asynchronous to clk
- cs_n      input   1           SPI chip select from master, active low
- mosi      input   1           serial data from master
- miso      output  1           serial data to master
- tx_data   input   DATA_WIDTH  byte to transmit on next word
- tx_load   input   1           write strobe for tx_data; accepted only when tx_ready=1
- tx_ready  output  1           tx holding buffer empty
- rx_data   output  DATA_WIDTH  last received word; held until next word completes
- rx_valid  output  1           one-clk pulse, rx_data updated
- busy      output  1           frame active (synchronised cs_n low)

Behaviour:
- Reset (rst_n low, async): miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, bit counter=0, shift registers=0, FSM=IDLE.
- Synchronisation: sclk, mosi and cs_n each pass through SYNC_STAGES flops. Edges are detected by comparing the last two synchronised samples of sclk.
- Timing requirement: sclk high and low phases each >= SYNC_STAGES+2 clk periods; cs_n setup to first sclk rise >= SYNC_STAGES+2 clk periods.
- FSM has two states, IDLE and SHIFT.
  - IDLE -> SHIFT on synchronised cs_n falling.
  - SHIFT -> IDLE on synchronised cs_n rising.
  - busy=1 exactly while in SHIFT.
- Word start occurs on entry to SHIFT, and on the clk after a word completes while still in SHIFT (back-to-back words in one frame):
  - If the tx buffer is full, it is copied to the tx shift register and tx_ready returns to 1.
  - If the buffer is empty (underrun), the shift register loads all zeros.
  - miso drives the shift register MSB from the clk after the word start.
- Rising sclk edge (detected) in SHIFT: shift the synchronised mosi into the rx shift register LSB and increment the bit counter.
- Falling sclk edge (detected) in SHIFT: shift the tx register left by one; miso = new MSB.
  - On the falling edge after the last bit, no shift is performed; the word start reload applies instead.
- Word completion: the bit counter reaches DATA_WIDTH on a rising edge.
  - On the next clk: rx_data <= rx shift register, rx_valid=1 for exactly 1 clk, bit counter <= 0.
  - rx_valid latency: SYNC_STAGES+2 clk after the DATA_WIDTH-th sclk rise at the pin.
- tx_load handshake:
  - tx_load with tx_ready=1 captures tx_data; tx_ready=0 from the next clk.
  - tx_load with tx_ready=0 is ignored; the buffer is unchanged.
  - tx_load in the same clk as a word start with an empty buffer: the word transmits zeros, and the new byte is held for the following word.
- cs_n rising mid-word: the partial word is discarded, with no rx_valid; bit counter <= 0, miso <= 0. The tx buffer content and tx_ready are preserved.
- sclk edges while in IDLE are ignored; miso stays 0.
- rst_n asserted mid-frame: immediate return to reset values. The frame is resumed only after cs_n is observed high and then low again.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_EN.
- Defined:
  - Adds output port overrun (1 bit, reset 0).
  - overrun is set sticky when a word completes while the previous rx_valid word is unacknowledged.
  - Adds input rx_ack (1 bit). rx_ack=1 acknowledges the current word and clears overrun.
  - rx_data is overwritten regardless of overrun.
- Not defined: no overrun or rx_ack ports. Every word completion updates rx_data with no tracking.

Test Plan:
1. Reset check: hold rst_n=0 with random inputs -> miso=0, tx_ready=1, rx_valid=0, busy=0, rx_data=0x00.
2. Single word: tx_load 0x3C, then master sends 0xAA in one cs_n frame -> rx_data=0xAA with one rx_valid pulse; master samples 0x3C on miso; tx_ready returns to 1 at word start.
3. Back-to-back frames: master sends 0x91, 0xF0, 0x12 in three separate frames with tx_load 0x01, 0x02, 0x03 before each -> three rx_valid pulses with rx_data 0x91, 0xF0, 0x12; master receives 0x01, 0x02, 0x03.
4. Underrun: no tx_load, master sends 0x55 -> miso all zeros (master reads 0x00); rx_data=0x55.
5. Abort: cs_n rises after 5 bits of 0xFF -> no rx_valid, rx_data unchanged, miso=0. The next full frame with 0xC3 gives rx_data=0xC3.
6. With SPI_SLAVE_OVERRUN_EN: two words 0xA5 then 0x5A in one frame with no rx_ack -> overrun=1 after the second word, rx_data=0x5A; rx_ack clears overrun to 0.
